// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: syncs ps2_clk/ps2_data, checks 11-bit frames, queues good scan codes in a 2^ADDR_W FIFO.
// Latency: a byte is visible on data/ready/level one clk after the stop-bit sample edge (about 3 clk after the ps2_clk fall).
// Backpressure: none toward the keyboard; a good frame arriving while full with no pop is dropped and sets sticky overflow.
// Optional macro PS2_PREFIX_DECODE_EN folds E0/F0 prefixes into is_ext/is_break flags stored with each entry.
module ps2_keyboard_rx_fifo #(
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 17
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              nextdata_n,
  output logic [7:0]        data,
  output logic              is_break,
  output logic              is_ext,
  output logic              ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              parity_err,
  output logic              frame_err
);

`ifdef PS2_PREFIX_DECODE_EN
  localparam int MEM_W = 10;
`else
  localparam int MEM_W = 8;
`endif
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        clk_sync;
  logic [1:0]        dat_sync;
  logic              sampling;
  logic              rx_bit;
  logic [3:0]        cnt;
  logic [9:0]        shift_buf;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout;
  logic              bad_start;
  logic              frame_done;
  logic              stop_bad;
  logic              par_bad;
  logic              byte_good;
  logic [7:0]        rx_byte;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              full;
  logic              drop;
  logic [MEM_W-1:0]  wr_entry;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_next;
`ifdef PS2_PREFIX_DECODE_EN
  logic              ext_pend;
  logic              brk_pend;
  logic              is_prefix;
`endif

  // Bring the asynchronous PS/2 lines into the clk domain; data lags one flop less so it lines up with clk_sync[1].
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Frame decode: falling-edge detect, error classification and the good-byte push request.
  always_comb begin
    sampling   = clk_sync[2] & ~clk_sync[1];
    rx_bit     = dat_sync[1];
    rx_byte    = shift_buf[8:1];
    timeout    = (cnt != 4'd0) && !sampling && (to_cnt == TO_W'(TIMEOUT_CYCLES));
    bad_start  = sampling && (cnt == 4'd0) && rx_bit;
    frame_done = sampling && (cnt == 4'd10);
    // Start bit is always 0 once stored, but folding it in keeps the frame check self-contained.
    stop_bad   = frame_done && (!rx_bit || shift_buf[0]);
    par_bad    = frame_done && !stop_bad && !(^shift_buf[9:1]);
    byte_good  = frame_done && !stop_bad && (^shift_buf[9:1]);
`ifdef PS2_PREFIX_DECODE_EN
    is_prefix  = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
    push_req   = byte_good && !is_prefix;
    wr_entry   = {ext_pend, brk_pend, rx_byte};
`else
    push_req   = byte_good;
    wr_entry   = rx_byte;
`endif
    pop        = ready && !nextdata_n;
    full       = (level == FULL_LVL);
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end
  end

  // Bit counter, shift buffer and inter-bit timeout; a timeout throws away the partial frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt       <= 4'd0;
      shift_buf <= 10'd0;
      to_cnt    <= '0;
    end else if (sampling) begin
      to_cnt <= '0;
      if (cnt == 4'd0 && rx_bit) begin
        cnt <= 4'd0;
      end else if (cnt < 4'd10) begin
        shift_buf[cnt] <= rx_bit;
        cnt            <= cnt + 1'b1;
      end else begin
        cnt <= 4'd0;
      end
    end else if (cnt == 4'd0) begin
      to_cnt <= '0;
    end else if (timeout) begin
      cnt    <= 4'd0;
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Registered one-cycle error pulses; a bad stop bit masks a simultaneous parity error.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= par_bad;
      frame_err  <= bad_start || stop_bad || timeout;
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  // Prefix tracking: E0/F0 arm flags for the next real code; any error or dropped push disarms them.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (par_bad || stop_bad || bad_start || timeout || drop) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_good) begin
      if (rx_byte == 8'hE0) begin
        ext_pend <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end
`endif

  // FIFO storage: not reset, contents only meaningful while ready is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers, fill level, registered non-empty flag and sticky overflow.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_next;
      ready    <= (level_next != '0);
      overflow <= overflow || drop;
    end
  end

  // Head-of-queue outputs; flags are gated by ready so they read 0 while empty.
  always_comb begin
    data = mem[rd_ptr][7:0];
`ifdef PS2_PREFIX_DECODE_EN
    is_ext   = ready && mem[rd_ptr][9];
    is_break = ready && mem[rd_ptr][8];
`else
    is_ext   = 1'b0;
    is_break = 1'b0;
`endif
  end

endmodule
